// File: rtl/instr_encoder_if.sv
// Encode-request channel: one mnemonic plus its operand fields per valid/ready handshake.
interface instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  mnem;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [15:0] imm;
   logic [25:0] target;

   modport master (
      output in_valid,
      output mnem,
      output rs,
      output rt,
      output rd,
      output imm,
      output target,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  mnem,
      input  rs,
      input  rt,
      input  rd,
      input  imm,
      input  target,
      output in_ready
   );
endinterface

// File: rtl/instr_encoder.sv
// Packs mnemonic/operand requests into 32-bit MIPS words and streams them into
// consecutive instruction-memory addresses through a stallable write port.
module instr_encoder #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = 6
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   instr_encoder_if.slave      req,
   output logic                mem_we,
   input  logic                mem_ready,
   output logic [AW-1:0]       mem_addr,
   output logic [31:0]         mem_wdata,
   output logic [AW:0]         count,
   output logic                full,
   output logic                err
);

   localparam logic [AW:0]   LastCount = (AW+1)'(DEPTH - 1);
   localparam logic [AW+1:0] Capacity  = (AW+2)'(DEPTH);

   typedef enum logic [0:0] {StLoad, StFull} state_e;

   state_e        state_q, state_d;
   logic          pend_q, pend_d;
   logic [31:0]   word_q, word_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW:0]   count_q, count_d;
   logic          err_q, err_d;

   logic [31:0]   enc_word;
   logic          enc_legal;
   logic [AW+1:0] occupancy;
   logic          room;
   logic          accept;
   logic          wr_done;

   always_comb begin
      enc_word  = '0;
      enc_legal = 1'b1;
      case (req.mnem)
         5'd0:  enc_word = {6'b000000, req.rs, req.rt, req.rd, 5'b00000, 6'b100000};
         5'd1:  enc_word = {6'b000000, req.rs, req.rt, req.rd, 5'b00000, 6'b100010};
         5'd2:  enc_word = {6'b000000, req.rs, req.rt, req.rd, 5'b00000, 6'b100100};
         5'd3:  enc_word = {6'b000000, req.rs, req.rt, req.rd, 5'b00000, 6'b100101};
         5'd4:  enc_word = {6'b000000, req.rs, req.rt, req.rd, 5'b00000, 6'b101010};
         5'd5:  enc_word = {6'b000000, req.rs, 15'b0, 6'b001000};
         5'd6:  enc_word = {6'b100011, req.rs, req.rt, req.imm};
         5'd7:  enc_word = {6'b101011, req.rs, req.rt, req.imm};
         5'd8:  enc_word = {6'b000100, req.rs, req.rt, req.imm};
         5'd9:  enc_word = {6'b000101, req.rs, req.rt, req.imm};
         5'd10: enc_word = {6'b001000, req.rs, req.rt, req.imm};
         5'd11: enc_word = {6'b001101, req.rs, req.rt, req.imm};
         5'd12: enc_word = {6'b001100, req.rs, req.rt, req.imm};
         5'd13: enc_word = {6'b001110, req.rs, req.rt, req.imm};
         5'd14: enc_word = {6'b001010, req.rs, req.rt, req.imm};
         5'd15: enc_word = {6'b001111, 5'b00000, req.rt, req.imm};
         5'd16: enc_word = {6'b000010, req.target};
         5'd17: enc_word = {6'b000011, req.target};
         5'd18: enc_word = {6'b100001, req.rs, req.rt, req.imm};
         5'd19: enc_word = {6'b100000, req.rs, req.rt, req.imm};
         5'd20: enc_word = {6'b100100, req.rs, req.rt, req.imm};
         5'd21: enc_word = {6'b000110, req.rs, 5'b00000, req.imm};
         default: enc_legal = 1'b0;
      endcase
   end

   // Words already written plus the one in flight must stay within capacity.
   always_comb begin
      occupancy = {1'b0, count_q} + {{(AW+1){1'b0}}, pend_q};
      room      = occupancy < Capacity;
   end

   always_comb begin
      mem_we       = pend_q && (state_q == StLoad);
      wr_done      = mem_we && mem_ready;
      req.in_ready = !reset && !clear && (state_q == StLoad) && (!pend_q || mem_ready) && room;
      accept       = req.in_valid && req.in_ready;
   end

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      word_d  = word_q;
      addr_d  = addr_q;
      count_d = count_q;
      err_d   = err_q;
      if (clear) begin
         state_d = StLoad;
         pend_d  = 1'b0;
         word_d  = '0;
         addr_d  = '0;
         count_d = '0;
         err_d   = 1'b0;
      end else begin
         if (wr_done) begin
            pend_d  = 1'b0;
            count_d = count_q + (AW+1)'(1);
            // The last slot does not advance the address: no wrap-around.
            if (count_q == LastCount) begin
               state_d = StFull;
            end else begin
               addr_d = addr_q + AW'(1);
            end
         end
         // A new word may replace one completing this cycle, giving one word per cycle.
         if (accept) begin
            if (enc_legal) begin
               pend_d = 1'b1;
               word_d = enc_word;
            end else begin
               err_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StLoad;
         pend_q  <= 1'b0;
         word_q  <= '0;
         addr_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         word_q  <= word_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      mem_addr  = addr_q;
      mem_wdata = word_q;
      count     = count_q;
      full      = (state_q == StFull);
      err       = err_q;
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, throughput, stalls, illegal codes,
// fill to capacity, clear and reset mid-stall.
module tb_instr_encoder;

   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          clear = 1'b0;
   logic          mem_we;
   logic          mem_ready = 1'b1;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [AW:0]   count;
   logic          full;
   logic          err;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;

   logic [AW-1:0] wr_addr [$];
   logic [31:0]   wr_data [$];
   int            wr_cyc  [$];

   instr_encoder_if req ();

   instr_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .req       (req),
      .mem_we    (mem_we),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .count     (count),
      .full      (full),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Log every completed memory write with the cycle it happened in.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset && !clear && mem_we && mem_ready) begin
         wr_addr.push_back(mem_addr);
         wr_data.push_back(mem_wdata);
         wr_cyc.push_back(cyc);
      end
   end

   // Encoding table, common fields rs=3 rt=4 rd=5 imm=0x00A5 target=0x0123456.
   logic [4:0]  tm [19] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd7, 5'd9, 5'd10, 5'd11,
                            5'd12, 5'd13, 5'd14, 5'd18, 5'd19, 5'd20, 5'd15, 5'd21, 5'd17};
   logic [31:0] tw [19] = '{32'h00642820, 32'h00642822, 32'h00642824, 32'h00642825,
                            32'h0064282A, 32'h00600008, 32'hAC6400A5, 32'h146400A5,
                            32'h206400A5, 32'h346400A5, 32'h306400A5, 32'h386400A5,
                            32'h286400A5, 32'h846400A5, 32'h806400A5, 32'h906400A5,
                            32'h3C0400A5, 32'h186000A5, 32'h0C123456};
   logic [31:0] first5 [5] = '{32'h8C020004, 32'h03E00008, 32'h3C051234, 32'h1022FFFF,
                               32'h08000010};

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic flush_log();
      wr_addr.delete();
      wr_data.delete();
      wr_cyc.delete();
   endtask

   // Presents a request and returns just after the accepting edge; in_valid stays high.
   task automatic send(input logic [4:0] m, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [15:0] i, input logic [25:0] tg,
                       output int waited);
      waited = 0;
      req.mnem = m; req.rs = s; req.rt = t; req.rd = d; req.imm = i; req.target = tg;
      req.in_valid = 1'b1;
      forever begin
         #1;
         if (req.in_ready) break;
         if (waited == 20) begin
            check_eq("accept_timeout", 64'(waited), 64'(0));
            req.in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         waited++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req.in_valid = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      #1;
      check_eq("clear_cycle_in_ready", 64'(req.in_ready), 64'(0));
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   initial begin
      int w;
      int base;
      req.in_valid = 1'b0;
      req.mnem = '0; req.rs = '0; req.rt = '0; req.rd = '0; req.imm = '0; req.target = '0;

      // Reset values
      step(); step();
      reset = 1'b0;
      check_eq("rst_mem_we", 64'(mem_we), 64'(0));
      check_eq("rst_addr", 64'(mem_addr), 64'(0));
      check_eq("rst_wdata", 64'(mem_wdata), 64'(0));
      check_eq("rst_count", 64'(count), 64'(0));
      check_eq("rst_full", 64'(full), 64'(0));
      check_eq("rst_err", 64'(err), 64'(0));
      #1;
      check_eq("rst_in_ready", 64'(req.in_ready), 64'(1));

      // Single ADD: word visible one cycle after acceptance
      send(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, w);
      idle();
      check_eq("add_we", 64'(mem_we), 64'(1));
      check_eq("add_addr", 64'(mem_addr), 64'(0));
      check_eq("add_wdata", 64'(mem_wdata), 64'h00221820);
      check_eq("add_count_before", 64'(count), 64'(0));
      step();
      check_eq("add_count_after", 64'(count), 64'(1));
      check_eq("add_we_drop", 64'(mem_we), 64'(0));

      // Back-to-back stream, then the encoding table in the same stream
      do_clear();
      flush_log();
      send(5'd6, 5'd0, 5'd2, 5'd0, 16'h0004, 26'h0, w);
      send(5'd5, 5'd31, 5'd0, 5'd0, 16'h0, 26'h0, w);
      check_eq("b2b_wait_jr", 64'(w), 64'(0));
      send(5'd15, 5'd0, 5'd5, 5'd0, 16'h1234, 26'h0, w);
      check_eq("b2b_wait_lui", 64'(w), 64'(0));
      send(5'd8, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, w);
      check_eq("b2b_wait_beq", 64'(w), 64'(0));
      send(5'd16, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, w);
      check_eq("b2b_wait_j", 64'(w), 64'(0));
      for (int k = 0; k < 19; k++) begin
         send(tm[k], 5'd3, 5'd4, 5'd5, 16'h00A5, 26'h0123456, w);
         check_eq("tbl_wait", 64'(w), 64'(0));
      end
      idle();
      step(); step();
      check_eq("b2b_nwrites", 64'(wr_data.size()), 64'(24));
      check_eq("b2b_count", 64'(count), 64'(24));
      if (wr_data.size() == 24) begin
         for (int k = 0; k < 24; k++) begin
            check_eq($sformatf("b2b_addr%0d", k), 64'(wr_addr[k]), 64'(k));
            check_eq($sformatf("b2b_cyc%0d", k), 64'(wr_cyc[k] - wr_cyc[0]), 64'(k));
            if (k < 5) check_eq($sformatf("b2b_data%0d", k), 64'(wr_data[k]), 64'(first5[k]));
            else check_eq($sformatf("enc_mnem%0d", tm[k-5]), 64'(wr_data[k]), 64'(tw[k-5]));
         end
      end

      // Stall: outputs hold while mem_ready is low, write completes once
      do_clear();
      flush_log();
      mem_ready = 1'b0;
      send(5'd10, 5'd3, 5'd4, 5'd0, 16'h00A5, 26'h0, w);
      idle();
      for (int k = 0; k < 3; k++) begin
         check_eq("stall_we", 64'(mem_we), 64'(1));
         check_eq("stall_addr", 64'(mem_addr), 64'(0));
         check_eq("stall_wdata", 64'(mem_wdata), 64'h206400A5);
         check_eq("stall_in_ready", 64'(req.in_ready), 64'(0));
         step();
      end
      mem_ready = 1'b1;
      #1;
      check_eq("stall_release_ready", 64'(req.in_ready), 64'(1));
      step();
      check_eq("stall_count", 64'(count), 64'(1));
      step(); step();
      check_eq("stall_count_once", 64'(count), 64'(1));
      check_eq("stall_nwrites", 64'(wr_data.size()), 64'(1));

      // Illegal mnemonic between two ADDIs
      do_clear();
      flush_log();
      check_eq("clr_err0", 64'(err), 64'(0));
      send(5'd10, 5'd3, 5'd4, 5'd0, 16'h0001, 26'h0, w);
      send(5'd25, 5'd3, 5'd4, 5'd0, 16'h0007, 26'h0, w);
      send(5'd10, 5'd3, 5'd4, 5'd0, 16'h0002, 26'h0, w);
      idle();
      check_eq("ill_err", 64'(err), 64'(1));
      step(); step();
      check_eq("ill_nwrites", 64'(wr_data.size()), 64'(2));
      check_eq("ill_count", 64'(count), 64'(2));
      if (wr_data.size() == 2) begin
         check_eq("ill_addr0", 64'(wr_addr[0]), 64'(0));
         check_eq("ill_data0", 64'(wr_data[0]), 64'h20640001);
         check_eq("ill_addr1", 64'(wr_addr[1]), 64'(1));
         check_eq("ill_data1", 64'(wr_data[1]), 64'h20640002);
      end
      step(); step();
      check_eq("ill_err_sticky", 64'(err), 64'(1));
      do_clear();
      check_eq("ill_err_cleared", 64'(err), 64'(0));

      // Fill to capacity, extra words refused
      flush_log();
      for (int k = 0; k < DEPTH; k++) send(5'd10, 5'd0, 5'd0, 5'd0, 16'(k), 26'h0, w);
      req.imm = 16'hBEEF;
      for (int k = 0; k < 4; k++) begin
         #1;
         check_eq("full_in_ready", 64'(req.in_ready), 64'(0));
         step();
      end
      idle();
      check_eq("full_flag", 64'(full), 64'(1));
      check_eq("full_count", 64'(count), 64'(DEPTH));
      check_eq("full_we", 64'(mem_we), 64'(0));
      check_eq("full_nwrites", 64'(wr_data.size()), 64'(DEPTH));
      if (wr_data.size() == DEPTH) begin
         for (int k = 0; k < DEPTH; k++) begin
            check_eq($sformatf("fill_addr%0d", k), 64'(wr_addr[k]), 64'(k));
            check_eq($sformatf("fill_data%0d", k), 64'(wr_data[k]), 64'(32'h20000000 | k));
         end
      end
      do_clear();
      check_eq("refill_count", 64'(count), 64'(0));
      check_eq("refill_full", 64'(full), 64'(0));
      #1;
      check_eq("refill_in_ready", 64'(req.in_ready), 64'(1));
      flush_log();
      send(5'd11, 5'd1, 5'd2, 5'd0, 16'h5555, 26'h0, w);
      idle();
      step();
      check_eq("refill_nwrites", 64'(wr_data.size()), 64'(1));
      if (wr_data.size() == 1) begin
         check_eq("refill_addr", 64'(wr_addr[0]), 64'(0));
         check_eq("refill_data", 64'(wr_data[0]), 64'h34225555);
      end

      // Clear during a stall drops the pending word
      do_clear();
      flush_log();
      mem_ready = 1'b0;
      send(5'd10, 5'd3, 5'd4, 5'd0, 16'h0009, 26'h0, w);
      idle();
      check_eq("clrstall_we_pre", 64'(mem_we), 64'(1));
      do_clear();
      check_eq("clrstall_we", 64'(mem_we), 64'(0));
      check_eq("clrstall_addr", 64'(mem_addr), 64'(0));
      check_eq("clrstall_count", 64'(count), 64'(0));
      mem_ready = 1'b1;
      step(); step();
      check_eq("clrstall_nwrites", 64'(wr_data.size()), 64'(0));

      // Reset during a stall with err set
      send(5'd30, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, w);
      mem_ready = 1'b0;
      send(5'd10, 5'd3, 5'd4, 5'd0, 16'h000A, 26'h0, w);
      idle();
      check_eq("rststall_err_pre", 64'(err), 64'(1));
      check_eq("rststall_we_pre", 64'(mem_we), 64'(1));
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_eq("rststall_we", 64'(mem_we), 64'(0));
      check_eq("rststall_addr", 64'(mem_addr), 64'(0));
      check_eq("rststall_wdata", 64'(mem_wdata), 64'(0));
      check_eq("rststall_count", 64'(count), 64'(0));
      check_eq("rststall_full", 64'(full), 64'(0));
      check_eq("rststall_err", 64'(err), 64'(0));
      mem_ready = 1'b1;
      step(); step();
      base = wr_data.size();
      check_eq("rststall_nwrites", 64'(base), 64'(0));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
